// File: rtl/vote_tally.sv
// ============================================================================
// Module   : vote_tally
// Function : four-phase CTS/RTR vote capture with saturating per-candidate tallies
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module vote_tally #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CTS,
  input  logic [3:0]       V_IN,
  input  logic             HOLD,
  input  logic             CLEAR,
  input  logic [1:0]       SEL,
  output logic             RTR,
  output logic [CNT_W-1:0] COUNT_OUT,
  output logic [CNT_W-1:0] TOTAL,
  output logic [CNT_W-1:0] BLANK_CNT,
  output logic [CNT_W-1:0] INVALID_CNT,
  output logic [1:0]       LEAD,
  output logic             LEAD_VALID,
  output logic             VOTE_STROBE
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_READY  = 2'd1,
    S_ACK    = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t           r_state;
  logic             r_rtr;
  logic             r_strobe;
  logic [3:0]       r_capture;
  logic [CNT_W-1:0] r_cnt [4];
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_blank;
  logic [CNT_W-1:0] r_invalid;
  logic [CNT_W-1:0] r_count_out;
  logic [1:0]       r_lead;
  logic             r_lead_valid;

  logic             w_accept;
  logic             w_apply;
  logic             w_blank;
  logic             w_single;
  logic [1:0]       w_lead;
  logic [CNT_W-1:0] w_max;
  logic             w_lead_valid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + C_ONE;
  endfunction

  // A transfer needs RTR already visible upstream, so the registered RTR gates it.
  assign w_accept = (r_state == S_READY) && r_rtr && !HOLD && CTS;
  assign w_apply  = (r_state == S_UPDATE);
  assign w_blank  = (r_capture == 4'd0);
  assign w_single = !w_blank && ((r_capture & (r_capture - 4'd1)) == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_INIT;
      r_rtr     <= 1'b0;
      r_strobe  <= 1'b0;
      r_capture <= 4'd0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_state <= S_READY;
          r_rtr   <= !HOLD;
        end
        S_READY: begin
          if (w_accept) begin
            r_capture <= V_IN;
            r_state   <= S_ACK;
            r_rtr     <= 1'b0;
          end else begin
            r_rtr <= !HOLD;
          end
        end
        S_ACK: begin
          r_rtr <= 1'b0;
          if (!CTS) begin
            r_state  <= S_UPDATE;
            r_strobe <= 1'b1;
          end
        end
        S_UPDATE: begin
          r_state <= S_READY;
          r_rtr   <= !HOLD;
        end
        default: begin
          r_state <= S_INIT;
          r_rtr   <= 1'b0;
        end
      endcase
    end
  end

  // Strict greater-than keeps the lowest index on a tie.
  always_comb begin
    w_lead = 2'd0;
    w_max  = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_cnt[i] > w_max) begin
        w_max  = r_cnt[i];
        w_lead = 2'(i);
      end
    end
    w_lead_valid = (w_max != '0);
  end

  always_ff @(posedge clk) begin
    if (reset || CLEAR) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
      r_total      <= '0;
      r_blank      <= '0;
      r_invalid    <= '0;
      r_lead       <= 2'd0;
      r_lead_valid <= 1'b0;
    end else begin
      if (w_apply) begin
        r_total <= sat_inc(r_total);
        if (w_blank) begin
          r_blank <= sat_inc(r_blank);
        end else if (w_single) begin
          for (int i = 0; i < 4; i++) begin
            if (r_capture[i]) begin
              r_cnt[i] <= sat_inc(r_cnt[i]);
            end
          end
        end else begin
          r_invalid <= sat_inc(r_invalid);
        end
      end
      r_lead       <= w_lead;
      r_lead_valid <= w_lead_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count_out <= '0;
    end else begin
      r_count_out <= r_cnt[SEL];
    end
  end

  assign RTR         = r_rtr;
  assign VOTE_STROBE = r_strobe;
  assign COUNT_OUT   = r_count_out;
  assign TOTAL       = r_total;
  assign BLANK_CNT   = r_blank;
  assign INVALID_CNT = r_invalid;
  assign LEAD        = r_lead;
  assign LEAD_VALID  = r_lead_valid;

endmodule

`default_nettype wire

// File: doc/vote_tally.md
VOTE_TALLY -- requirements
Module: vote_tally

Interface
REQ-001 Parameter CNT_W, default 8: width of every tally counter and of TOTAL.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 CTS  input  1  clear-to-send from the upstream voting stage; qualifies V_IN.
REQ-005 V_IN  input  4  vote code from the upstream stage; bit i = vote for candidate i.
REQ-006 HOLD  input  1  when 1, the block does not offer RTR (back-pressure).
REQ-007 CLEAR  input  1  synchronous clear of all tallies, without resetting the handshake.
REQ-008 SEL  input  2  selects the candidate counter shown on COUNT_OUT.
REQ-009 RTR  output  1  ready-to-receive toward the upstream stage; registered.
REQ-010 COUNT_OUT  output  CNT_W  registered copy of candidate counter CNT[SEL].
REQ-011 TOTAL  output  CNT_W  accepted votes (valid, blank and invalid), saturating.
REQ-012 BLANK_CNT  output  CNT_W  votes with V_IN = 4'b0000, saturating.
REQ-013 INVALID_CNT  output  CNT_W  votes with two or more bits set, saturating.
REQ-014 LEAD  output  2  index of the leading candidate; registered.
REQ-015 LEAD_VALID  output  1  1 when at least one candidate counter is nonzero.
REQ-016 VOTE_STROBE  output  1  one-cycle pulse in the cycle the tallies are updated.

Function
REQ-017 FSM states: S_INIT, S_READY, S_ACK, S_UPDATE; a state register drives RTR (RTR=1 only in S_READY with HOLD=0).
REQ-018 S_INIT: RTR=0 for one cycle, then S_READY.
REQ-019 S_READY: with HOLD=0 and CTS=1, latch V_IN into a 4-bit capture register and go to S_ACK; with HOLD=1 ignore CTS, stay, RTR=0.
REQ-020 S_ACK: RTR=0; stay while CTS=1; on CTS=0 go to S_UPDATE (four-phase handshake; the capture register is not reloaded here).
REQ-021 S_UPDATE: apply the captured vote, assert VOTE_STROBE, go to S_READY; exactly one update per handshake.
REQ-022 Classification of the captured vote: exactly one bit set -> the matching CNT[i] +1; zero bits -> BLANK_CNT +1; two or more bits -> INVALID_CNT +1; TOTAL +1 in all three cases.
REQ-023 All counters saturate at 2^CNT_W-1; an increment at the maximum leaves the value unchanged, with no wrap to 0.
REQ-024 CLEAR=1 zeroes CNT[0..3], TOTAL, BLANK_CNT, INVALID_CNT, LEAD, LEAD_VALID next cycle; the FSM state and RTR are unaffected.
REQ-025 CLEAR coincident with S_UPDATE: CLEAR wins, the vote is discarded, VOTE_STROBE is still pulsed.
REQ-026 LEAD/LEAD_VALID are recomputed from the counter values one cycle after any counter change; on a tie the lowest index wins; LEAD=0 when LEAD_VALID=0.
REQ-027 COUNT_OUT = CNT[SEL] registered, so 1-cycle latency from a SEL change or a counter change.
REQ-028 CTS held high across S_UPDATE into S_READY is treated as a new transfer (upstream is responsible for deasserting).

Reset
REQ-029 reset=1 forces S_INIT, RTR=0, VOTE_STROBE=0, capture register=0, all counters, COUNT_OUT, LEAD and LEAD_VALID to 0 at the next rising clk, regardless of state.
REQ-030 reset mid-handshake (S_ACK or S_UPDATE) discards the pending vote; no counter changes afterward.
REQ-031 reset has priority over CLEAR, HOLD and CTS.

Verification
REQ-032 Reset, then idle: RTR=0 for 1 cycle, then RTR=1; all outputs 0.
REQ-033 Handshake V_IN=4'b0100 (CTS up, wait RTR low, CTS down): one VOTE_STROBE; CNT[2]=1, TOTAL=1, SEL=2 -> COUNT_OUT=1, LEAD=2, LEAD_VALID=1.
REQ-034 Votes 0000, 0011, 0001, 0010: BLANK_CNT=1, INVALID_CNT=1, CNT[0]=1, CNT[1]=1, TOTAL=4, LEAD=0 (tie -> lowest index).
REQ-035 CNT_W=4, 17 votes of 4'b1000: CNT[3]=15, TOTAL=15, no wrap.
REQ-036 HOLD=1 with CTS=1 for 10 cycles: RTR stays 0, no capture; on HOLD=0, RTR rises and the vote is accepted.
REQ-037 CLEAR asserted in the S_UPDATE cycle: all counters 0, VOTE_STROBE pulses; reset asserted in S_ACK: no update, RTR=0, then the S_INIT sequence.
